seq_arith_unit: RTL and testbench
=================================

SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width (legal range 4..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port a, b  input  WIDTH each  unsigned operands, sampled only when an operation is accepted.
REQ-005 The block SHALL have port func  input  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-006 The block SHALL have port enable  input  1  start request.
REQ-007 The block SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-008 The block SHALL have port arith_flag  output  1  one-cycle result-valid pulse.
REQ-009 The block SHALL have port arith_out  output  WIDTH  result: sum, difference, product low half, or quotient.
REQ-010 The block SHALL have port arith_out_hi  output  WIDTH  product high half or remainder; zero for ADD/SUB.
REQ-011 The block SHALL have port carry_out  output  1  ADD carry, or SUB borrow (1 when a<b); zero for MUL/DIV.
REQ-012 The block SHALL have port div_by_zero  output  1  set by a DIV with b==0; zero otherwise.

Function
REQ-013 The FSM SHALL have exactly the states IDLE and RUN.
REQ-014 In IDLE, enable=1 at an edge SHALL accept the operation and capture a, b and func at that edge.
REQ-015 The block SHALL ignore enable while in RUN; no queueing.
REQ-016 ADD/SUB SHALL complete in one cycle:
  - results and arith_flag=1 are visible after the accepting edge;
  - state stays IDLE; busy stays 0.
REQ-017 MUL SHALL use an iterative shift-add, one bit per cycle:
  - accepting edge moves IDLE->RUN and sets busy=1;
  - the {arith_out_hi, arith_out} 2*WIDTH product and arith_flag=1 are presented after edge k+WIDTH (k = accepting edge);
  - the same edge returns RUN->IDLE and clears busy.
REQ-018 DIV with b!=0 SHALL use a restoring divide, one quotient bit per cycle, with the same latency and busy timing as MUL:
  - arith_out = a/b;
  - arith_out_hi = a%b.
REQ-019 DIV with b==0 SHALL complete in one cycle from IDLE with arith_out all-ones, arith_out_hi=a, div_by_zero=1, arith_flag=1.
REQ-020 arith_flag SHALL be high for exactly one cycle per accepted operation.
REQ-021 arith_out, arith_out_hi, carry_out and div_by_zero SHALL hold their values until the next operation completes.
REQ-022 Intermediate MUL/DIV values SHALL NOT appear on the result outputs while busy=1.
REQ-023 enable=1 in the completion cycle of a MUL/DIV SHALL be accepted at the next edge, since state is then IDLE; back-to-back ADDs SHALL produce one arith_flag pulse per cycle.

Reset
REQ-024 rst=0 SHALL immediately, independent of clk, force:
  - state to IDLE;
  - busy, arith_flag, carry_out and div_by_zero to 0;
  - arith_out, arith_out_hi and all internal iteration registers to 0.
REQ-025 Reset asserted mid-MUL/DIV SHALL abort the operation with no arith_flag pulse.
REQ-026 After rst is released, the first rising edge SHALL be able to accept an operation.

Configuration
REQ-027 When macro SEQ_ARITH_OVF_EN is defined, the block SHALL add port overflow  output  1, set on completion as follows:
  - ADD/SUB: 1 on two's-complement signed overflow;
  - MUL: 1 when arith_out_hi != 0;
  - DIV: always 0;
  - held like the other results; reset value 0.
REQ-028 When SEQ_ARITH_OVF_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (WIDTH=16)
REQ-029 ADD a=FFFF, b=0001:
  - arith_out=0000, carry_out=1;
  - arith_flag pulses in the cycle after the accepting edge; busy stays 0.
REQ-030 MUL a=1234, b=0100:
  - busy high for 16 cycles;
  - arith_out=3400, arith_out_hi=0012, single arith_flag pulse at completion.
REQ-031 DIV a=0064, b=0007 with enable held high throughout:
  - arith_out=000E, arith_out_hi=0002 after 16 cycles;
  - enable pulses during busy are ignored;
  - next operation accepted at the edge after completion.
REQ-032 DIV a=1234, b=0000:
  - one-cycle completion;
  - arith_out=FFFF, arith_out_hi=1234, div_by_zero=1.
REQ-033 Start MUL, assert rst at cycle 5 of RUN:
  - all outputs 0 at once; no arith_flag pulse;
  - after release, SUB a=0003, b=0005 gives arith_out=FFFE, carry_out=1.
REQ-034 With SEQ_ARITH_OVF_EN defined:
  - ADD 7FFF+0001 gives overflow=1;
  - MUL 00FF*00FF gives overflow=0;
  - MUL 0100*0100 gives overflow=1.

Source files
------------

// File: rtl/seq_arith_unit.sv
// Sequential ADD/SUB/MUL/DIV unit; SEQ_ARITH_OVF_EN adds a registered overflow output.
// Latency: ADD/SUB and divide-by-zero 1 cycle, MUL/DIV WIDTH cycles after the accepting edge.
// No backpressure: enable is ignored while busy; results hold until the next completion.
module seq_arith_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       func,
  input  logic             enable,
  output logic             busy,
  output logic             arith_flag,
  output logic [WIDTH-1:0] arith_out,
  output logic [WIDTH-1:0] arith_out_hi,
  output logic             carry_out,
  output logic             div_by_zero
`ifdef SEQ_ARITH_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SUB = 2'b01;
  localparam logic [1:0] F_DIV = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic            op_div;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] opa_q;   // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] acc_hi;  // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier shifting out / dividend shifting into quotient

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa_q} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opa_q};
  // True difference is below the divisor, so the low WIDTH bits are exact.
  assign div_sub   = div_shift[WIDTH-1:0] - opa_q;

`ifdef SEQ_ARITH_OVF_EN
  logic add_ovf;
  logic sub_ovf;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
`endif

  always_comb begin
    nxt_hi = '0;
    nxt_lo = '0;
    if (op_div) begin
      nxt_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      op_div       <= 1'b0;
      cnt          <= '0;
      opa_q        <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      busy         <= 1'b0;
      arith_flag   <= 1'b0;
      arith_out    <= '0;
      arith_out_hi <= '0;
      carry_out    <= 1'b0;
      div_by_zero  <= 1'b0;
`ifdef SEQ_ARITH_OVF_EN
      overflow     <= 1'b0;
`endif
    end else begin
      arith_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            case (func)
              F_ADD: begin
                arith_out    <= add_full[WIDTH-1:0];
                arith_out_hi <= '0;
                carry_out    <= add_full[WIDTH];
                div_by_zero  <= 1'b0;
                arith_flag   <= 1'b1;
`ifdef SEQ_ARITH_OVF_EN
                overflow     <= add_ovf;
`endif
              end
              F_SUB: begin
                arith_out    <= sub_full[WIDTH-1:0];
                arith_out_hi <= '0;
                carry_out    <= sub_full[WIDTH];
                div_by_zero  <= 1'b0;
                arith_flag   <= 1'b1;
`ifdef SEQ_ARITH_OVF_EN
                overflow     <= sub_ovf;
`endif
              end
              default: begin
                if (func == F_DIV && b == '0) begin
                  arith_out    <= '1;
                  arith_out_hi <= a;
                  carry_out    <= 1'b0;
                  div_by_zero  <= 1'b1;
                  arith_flag   <= 1'b1;
`ifdef SEQ_ARITH_OVF_EN
                  overflow     <= 1'b0;
`endif
                end else begin
                  op_div <= func[0];
                  opa_q  <= func[0] ? b : a;
                  acc_hi <= '0;
                  acc_lo <= func[0] ? a : b;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
                end
              end
            endcase
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          // Results only reach the outputs on the final iteration.
          if (cnt == CW'(WIDTH - 1)) begin
            arith_out    <= nxt_lo;
            arith_out_hi <= nxt_hi;
            carry_out    <= 1'b0;
            div_by_zero  <= 1'b0;
            arith_flag   <= 1'b1;
`ifdef SEQ_ARITH_OVF_EN
            overflow     <= !op_div && (nxt_hi != '0);
`endif
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit (WIDTH=16): vector table plus scoreboard keyed on completion cycle.
module tb_seq_arith_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a, b;
  logic [1:0]    func;
  logic          enable;
  logic          busy, arith_flag, carry_out, div_by_zero;
  logic [W-1:0]  arith_out, arith_out_hi;
`ifdef SEQ_ARITH_OVF_EN
  logic          overflow;
`endif

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .func(func), .enable(enable),
    .busy(busy), .arith_flag(arith_flag), .arith_out(arith_out),
    .arith_out_hi(arith_out_hi), .carry_out(carry_out), .div_by_zero(div_by_zero)
`ifdef SEQ_ARITH_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   f;
    logic [W-1:0] x, y;
    logic [W-1:0] out, hi;
    logic         c, dz, ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] out, hi;
    logic         c, dz, ovf;
    int           done;
  } exp_t;

  exp_t         sbq[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] last_out = '0;
  vec_t         tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [1:0] f, input logic [W-1:0] y);
    return (f == 2'd2 || (f == 2'd3 && y != '0)) ? W : 0;
  endfunction

  function automatic exp_t model(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx, sy, s;
    logic [2*W-1:0] p;
    e = '{out: '0, hi: '0, c: 1'b0, dz: 1'b0, ovf: 1'b0, done: 0};
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (f)
      2'd0: begin
        e.out = x + y;
        e.c   = (int'(x) + int'(y)) > 65535;
        s     = sx + sy;
        e.ovf = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        e.out = x - y;
        e.c   = x < y;
        s     = sx - sy;
        e.ovf = (s > 32767) || (s < -32768);
      end
      2'd2: begin
        p     = {16'h0, x} * {16'h0, y};
        e.out = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.ovf = e.hi != '0;
      end
      default: begin
        if (y == '0) begin
          e.out = '1;
          e.hi  = x;
          e.dz  = 1'b1;
        end else begin
          e.out = x / y;
          e.hi  = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    int guard = 0;
    int lat;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy got 1 expected 0 within 100 cycles");
    end
    lat    = lat_of(f, y);
    func   = f;
    a      = x;
    b      = y;
    enable = 1'b1;
    e.done = cyc + 1 + lat;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, {31'b0, lat != 0});
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (arith_flag) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flag: arith_flag got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("arith_out", {16'b0, arith_out}, {16'b0, e.out});
        chk("arith_out_hi", {16'b0, arith_out_hi}, {16'b0, e.hi});
        chk("carry_out", {31'b0, carry_out}, {31'b0, e.c});
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
        chk("done_cycle", cyc, e.done);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
`ifdef SEQ_ARITH_OVF_EN
        chk("overflow", {31'b0, overflow}, {31'b0, e.ovf});
`endif
        last_out = e.out;
      end
    end
  end

  initial begin
    exp_t e;
    int   guard;
    logic [1:0]   rf;
    logic [W-1:0] rx, ry;

    tbl[0]  = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2'd0, 16'h1234, 16'h1111, 16'h2345, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'd1, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'd2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{2'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{2'd2, 16'h00FF, 16'h00FF, 16'hFE01, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'd3, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'd3, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{2'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'd3, 16'h0003, 16'h0005, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2'd2, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1};

    rst = 1'b0; enable = 1'b0; a = '0; b = '0; func = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_flag", {31'b0, arith_flag}, 32'd0);
    chk("rst_out", {16'b0, arith_out}, 32'd0);
    chk("rst_hi", {16'b0, arith_out_hi}, 32'd0);
    chk("rst_carry", {31'b0, carry_out}, 32'd0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b1;

    // First op driven in the same cycle reset releases: first edge must accept it.
    for (int i = 0; i < 14; i++) begin
      e = '{out: tbl[i].out, hi: tbl[i].hi, c: tbl[i].c, dz: tbl[i].dz, ovf: tbl[i].ovf, done: 0};
      issue(tbl[i].f, tbl[i].x, tbl[i].y, e);
    end

    for (int i = 0; i < 8; i++) begin
      rf = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      issue(rf, rx, ry, model(rf, rx, ry));
    end

    // DIV with enable held high through busy; an ADD waits behind it.
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    func = 2'd3; a = 16'h0064; b = 16'h0007; enable = 1'b1;
    sbq.push_back('{out: 16'h000E, hi: 16'h0002, c: 1'b0, dz: 1'b0, ovf: 1'b0, done: cyc + 17});
    sbq.push_back('{out: 16'h0002, hi: 16'h0000, c: 1'b0, dz: 1'b0, ovf: 1'b0, done: cyc + 18});
    @(posedge clk);
    @(negedge clk);
    func = 2'd0; a = 16'h0001; b = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      chk("div_busy_held", {31'b0, busy}, 32'd1);
      chk("div_out_held", {16'b0, arith_out}, {16'b0, last_out});
      @(negedge clk);
    end
    @(negedge clk);
    enable = 1'b0;

    issue(2'd3, 16'h1234, 16'h0000, '{out: 16'hFFFF, hi: 16'h1234, c: 1'b0, dz: 1'b1, ovf: 1'b0, done: 0});

    // Reset in the middle of a MUL: outputs clear at once, no completion pulse.
    func = 2'd2; a = 16'h1234; b = 16'h0100; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_flag", {31'b0, arith_flag}, 32'd0);
    chk("abort_out", {16'b0, arith_out}, 32'd0);
    chk("abort_hi", {16'b0, arith_out_hi}, 32'd0);
    chk("abort_dz", {31'b0, div_by_zero}, 32'd0);
    chk("abort_carry", {31'b0, carry_out}, 32'd0);
`ifdef SEQ_ARITH_OVF_EN
    chk("abort_ovf", {31'b0, overflow}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(2'd1, 16'h0003, 16'h0005, '{out: 16'hFFFE, hi: 16'h0000, c: 1'b1, dz: 1'b0, ovf: 1'b0, done: 0});
    repeat (20) @(negedge clk);

    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("pending_results", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
